// File: rtl/random_roller.sv
// Decelerating random roller: samples a free-running entropy source at
// intervals that lengthen stage by stage, like a die slowing to rest.
module random_roller #(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned MAX_VAL         = 15,
    parameter int unsigned MODE            = 0,
    parameter int unsigned BASE_PERIOD     = 5000000,
    parameter int unsigned STEPS_PER_STAGE = 4,
    parameter int unsigned NUM_UPDATES     = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_stop,
    output logic [WIDTH-1:0] o_random_out,
    output logic             o_busy,
    output logic             o_update,
    output logic             o_done
);

    localparam int unsigned CNT_W   = 32;
    localparam int unsigned IDX_W   = 8;
    localparam int unsigned LFSR_W  = 16;
    localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cyc_cnt;
    logic [CNT_W-1:0]  interval;
    logic [CNT_W-1:0]  stage_cnt;
    logic [IDX_W-1:0]  upd_idx;
    logic [WIDTH-1:0]  ent_cnt;
    logic [LFSR_W-1:0] lfsr;
    logic [WIDTH-1:0]  sample;
    logic              hit;
    logic              last_upd;
    logic              stage_end;

    // Entropy sources run every cycle, independent of the roll state
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ent_cnt <= '0;
            lfsr    <= LFSR_SEED;
        end else begin
            ent_cnt <= (ent_cnt == WIDTH'(MAX_VAL)) ? '0 : ent_cnt + WIDTH'(1);
            lfsr    <= {lfsr[LFSR_W-2:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    assign sample    = (MODE == 1) ? lfsr[WIDTH-1:0] : ent_cnt;
    assign hit       = (cyc_cnt == interval - CNT_W'(1));
    assign last_upd  = (upd_idx == IDX_W'(NUM_UPDATES - 1));
    assign stage_end = (stage_cnt == CNT_W'(STEPS_PER_STAGE - 1));

    // Roll control; a start request always re-arms the schedule from scratch
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state        <= IDLE;
            o_random_out <= '0;
            o_busy       <= 1'b0;
            o_update     <= 1'b0;
            o_done       <= 1'b0;
            cyc_cnt      <= '0;
            interval     <= CNT_W'(BASE_PERIOD);
            stage_cnt    <= '0;
            upd_idx      <= '0;
        end else begin
            o_update <= 1'b0;
            o_done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        state     <= RUN;
                        o_busy    <= 1'b1;
                        cyc_cnt   <= '0;
                        interval  <= CNT_W'(BASE_PERIOD);
                        stage_cnt <= '0;
                        upd_idx   <= '0;
                    end
                end
                RUN: begin
                    if (i_start) begin
                        cyc_cnt   <= '0;
                        interval  <= CNT_W'(BASE_PERIOD);
                        stage_cnt <= '0;
                        upd_idx   <= '0;
                    end else if (i_stop) begin
                        state  <= IDLE;
                        o_busy <= 1'b0;
                        o_done <= 1'b1;
                    end else if (hit) begin
                        o_random_out <= sample;
                        o_update     <= 1'b1;
                        cyc_cnt      <= '0;
                        upd_idx      <= upd_idx + IDX_W'(1);
                        // Interval grows by one base period at each stage boundary
                        if (stage_end) begin
                            stage_cnt <= '0;
                            interval  <= interval + CNT_W'(BASE_PERIOD);
                        end else begin
                            stage_cnt <= stage_cnt + CNT_W'(1);
                        end
                        if (last_upd) begin
                            state  <= IDLE;
                            o_busy <= 1'b0;
                            o_done <= 1'b1;
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
